// File: rtl/clock_pkg.sv
// clock_pkg: shared types and widths for the BCD conversion arbiter.
// Holds FSM state encoding, digit/binary widths and requester indices.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int BIN_W   = 7;

  localparam int SEC = 0;
  localparam int MIN = 1;
  localparam int HR  = 2;

endpackage

// File: rtl/bcd2bin.sv
// bcd2bin: two-digit BCD to binary, 0..99.
// Digits above 9 are treated as 0 so the result never exceeds 99.
module bcd2bin
  import clock_pkg::*;
(
  input  logic [DIGIT_W-1:0] bcd_high,
  input  logic [DIGIT_W-1:0] bcd_low,
  output logic [BIN_W-1:0]   bin
);

  logic [DIGIT_W-1:0] hi;
  logic [DIGIT_W-1:0] lo;

  assign hi = (bcd_high > DIGIT_W'(9)) ? '0 : bcd_high;
  assign lo = (bcd_low  > DIGIT_W'(9)) ? '0 : bcd_low;

  assign bin = BIN_W'(hi) * BIN_W'(10) + BIN_W'(lo);

endmodule

// File: rtl/bcd_conv_arb.sv
// bcd_conv_arb: round-robin arbiter sharing one bcd2bin converter.
// Define BCD_ARB_DIGIT_CHECK_EN to report invalid digits on err_o.
module bcd_conv_arb
  import clock_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int ID_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [DIGIT_W*N_REQ-1:0] bcd_high_i,
  input  logic [DIGIT_W*N_REQ-1:0] bcd_low_i,
  output logic [N_REQ-1:0]         ack,
  output logic [BIN_W-1:0]         bin_o,
  output logic                     bin_vld,
  output logic [ID_W-1:0]          bin_id,
  output logic                     busy,
  output logic                     err_o
);

  state_t             state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    cur_id;
  logic [DIGIT_W-1:0] op_hi;
  logic [DIGIT_W-1:0] op_lo;

  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic [DIGIT_W-1:0] gnt_hi;
  logic [DIGIT_W-1:0] gnt_lo;
  logic [BIN_W-1:0]   conv_bin;

  // Two passes: above last_grant first, then wrap to index 0.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_hi  = '0;
    gnt_lo  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_vld && req[k] && k > int'(last_grant)) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(k);
        gnt_hi  = bcd_high_i[DIGIT_W*k +: DIGIT_W];
        gnt_lo  = bcd_low_i[DIGIT_W*k +: DIGIT_W];
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_vld && req[k]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(k);
        gnt_hi  = bcd_high_i[DIGIT_W*k +: DIGIT_W];
        gnt_lo  = bcd_low_i[DIGIT_W*k +: DIGIT_W];
      end
    end
  end

  bcd2bin u_conv (
    .bcd_high (op_hi),
    .bcd_low  (op_lo),
    .bin      (conv_bin)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= ID_W'(N_REQ-1);
      cur_id     <= '0;
      op_hi      <= '0;
      op_lo      <= '0;
      bin_o      <= '0;
      bin_id     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (gnt_vld) begin
            state  <= CONV;
            cur_id <= gnt_id;
            op_hi  <= gnt_hi;
            op_lo  <= gnt_lo;
          end
        end
        CONV: begin
          bin_o  <= conv_bin;
          bin_id <= cur_id;
          state  <= DONE;
        end
        DONE: begin
          last_grant <= bin_id;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy    = (state != IDLE);
  assign bin_vld = (state == DONE);

  always_comb begin
    ack = '0;
    if (bin_vld) ack[bin_id] = 1'b1;
  end

`ifdef BCD_ARB_DIGIT_CHECK_EN
  logic err_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (state == CONV) begin
      err_r <= (op_hi > DIGIT_W'(9)) || (op_lo > DIGIT_W'(9));
    end
  end

  assign err_o = bin_vld & err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_conv_arb.sv
// tb_bcd_conv_arb: directed and randomized checks for bcd_conv_arb.
// Honors BCD_ARB_DIGIT_CHECK_EN for err_o expectations.
module tb_bcd_conv_arb;

`ifdef BCD_ARB_DIGIT_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [11:0] bcd_high_i;
  logic [11:0] bcd_low_i;
  logic [2:0]  ack;
  logic [6:0]  bin_o;
  logic        bin_vld;
  logic [1:0]  bin_id;
  logic        busy;
  logic        err_o;

  int checks = 0;
  int errors = 0;

  bcd_conv_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .bcd_high_i (bcd_high_i),
    .bcd_low_i  (bcd_low_i),
    .ack        (ack),
    .bin_o      (bin_o),
    .bin_vld    (bin_vld),
    .bin_id     (bin_id),
    .busy       (busy),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic wait_vld(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bin_vld && n < 10);
    chk("vld_seen", bin_vld, 1);
  endtask

  function automatic logic [6:0] ref_bin(input logic [3:0] h,
                                         input logic [3:0] l);
    int hv;
    int lv;
    hv = (h > 9) ? 0 : int'(h);
    lv = (l > 9) ? 0 : int'(l);
    return 7'(hv * 10 + lv);
  endfunction

  int          n;
  int          g;
  int          waitc[3];
  logic [2:0]  rq;
  logic [2:0]  snap_req;
  logic [6:0]  snap_val[3];
  logic        snap_err[3];

  initial begin
    rst = 1'b1;
    req = '0;
    bcd_high_i = '0;
    bcd_low_i = '0;
    tick();
    tick();
    chk("rst_bin_o", bin_o, 0);
    chk("rst_bin_id", bin_id, 0);
    chk("rst_ack", ack, 0);
    chk("rst_vld", bin_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_o, 0);
    rst = 1'b0;

    // single seconds request 4/5
    bcd_high_i = {4'd0, 4'd0, 4'd4};
    bcd_low_i  = {4'd0, 4'd0, 4'd5};
    req = 3'b001;
    tick();
    chk("s1_busy", busy, 1);
    chk("s1_vld_early", bin_vld, 0);
    req = 3'b000;
    tick();
    chk("s1_vld", bin_vld, 1);
    chk("s1_bin", bin_o, 45);
    chk("s1_id", bin_id, 0);
    chk("s1_ack", ack, 3'b001);
    tick();
    chk("s1_vld_off", bin_vld, 0);
    chk("s1_hold", bin_o, 45);
    chk("s1_idle", busy, 0);

    // all three requesting, round robin from reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bcd_high_i = {4'd2, 4'd5, 4'd0};
    bcd_low_i  = {4'd3, 4'd9, 4'd7};
    req = 3'b111;
    wait_vld(n);
    chk("rr0_lat", n, 2);
    chk("rr0_id", bin_id, 0);
    chk("rr0_bin", bin_o, 7);
    wait_vld(n);
    chk("rr1_gap", n, 3);
    chk("rr1_id", bin_id, 1);
    chk("rr1_bin", bin_o, 59);
    chk("rr1_ack", ack, 3'b010);
    wait_vld(n);
    chk("rr2_gap", n, 3);
    chk("rr2_id", bin_id, 2);
    chk("rr2_bin", bin_o, 23);
    wait_vld(n);
    chk("rr3_gap", n, 3);
    chk("rr3_id", bin_id, 0);
    chk("rr3_bin", bin_o, 7);

    // invalid minutes tens digit
    bcd_high_i = {4'd0, 4'd12, 4'd0};
    bcd_low_i  = {4'd0, 4'd3, 4'd0};
    req = 3'b010;
    wait_vld(n);
    chk("bad_gap", n, 3);
    chk("bad_id", bin_id, 1);
    chk("bad_bin", bin_o, 3);
    chk("bad_err", err_o, CHK_EN);
    req = 3'b000;
    tick();
    chk("bad_err_off", err_o, 0);

    // operands change and req drops after grant
    bcd_high_i = {4'd0, 4'd0, 4'd1};
    bcd_low_i  = {4'd0, 4'd0, 4'd2};
    req = 3'b001;
    tick();
    bcd_high_i = {4'd0, 4'd0, 4'd9};
    bcd_low_i  = {4'd0, 4'd0, 4'd9};
    req = 3'b000;
    tick();
    chk("lat_vld", bin_vld, 1);
    chk("lat_bin", bin_o, 12);
    chk("lat_ack", ack, 3'b001);
    chk("lat_err", err_o, 0);
    tick();

    // reset while converting
    bcd_high_i = {4'd2, 4'd0, 4'd0};
    bcd_low_i  = {4'd3, 4'd0, 4'd7};
    req = 3'b100;
    tick();
    chk("ab_busy", busy, 1);
    rst = 1'b1;
    tick();
    chk("ab_idle", busy, 0);
    chk("ab_vld", bin_vld, 0);
    chk("ab_ack", ack, 0);
    chk("ab_bin", bin_o, 0);
    rst = 1'b0;
    req = 3'b111;
    wait_vld(n);
    chk("ab_lat", n, 2);
    chk("ab_id", bin_id, 0);
    chk("ab_ack0", ack, 3'b001);
    chk("ab_bin0", bin_o, 7);
    req = 3'b000;
    tick();

    // random run with fairness scoreboard
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rq = '0;
    snap_req = '0;
    for (int k = 0; k < 3; k++) begin
      waitc[k] = 0;
      snap_val[k] = '0;
      snap_err[k] = 1'b0;
    end
    for (int c = 0; c < 10000; c++) begin
      tick();
      chk("r_onehot", 32'($onehot0(ack)), 1);
      chk("r_ack", ack, bin_vld ? 3'(3'b001 << bin_id) : 3'b000);
      if (bin_vld) begin
        g = int'(bin_id);
        chk("r_owner", snap_req[g], 1);
        chk("r_bin", bin_o, snap_val[g]);
        chk("r_err", err_o, CHK_EN & snap_err[g]);
        for (int k = 0; k < 3; k++) begin
          if (k != g && snap_req[k]) begin
            waitc[k]++;
            chk("r_wait", 32'(waitc[k] <= 2), 1);
          end
        end
        waitc[g] = 0;
        if ($urandom_range(0, 1) == 1) rq[g] = 1'b0;
      end else begin
        chk("r_err_idle", err_o, 0);
      end
      for (int k = 0; k < 3; k++) begin
        if (!rq[k] && $urandom_range(0, 3) == 0) rq[k] = 1'b1;
        bcd_high_i[4*k +: 4] = 4'($urandom_range(0, 11));
        bcd_low_i[4*k +: 4]  = 4'($urandom_range(0, 11));
      end
      req = rq;
      if (!busy && rq != 3'b000) begin
        snap_req = rq;
        for (int k = 0; k < 3; k++) begin
          snap_val[k] = ref_bin(bcd_high_i[4*k +: 4], bcd_low_i[4*k +: 4]);
          snap_err[k] = (bcd_high_i[4*k +: 4] > 9) ||
                        (bcd_low_i[4*k +: 4] > 9);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arb.md
BCD_CONV_ARB -- requirements
Module: bcd_conv_arb

Interface
REQ-001 Parameter N_REQ, default 3: number of requesters (0 = seconds, 1 = minutes, 2 = hours).
REQ-002 Parameter ID_W, default 2: width of the requester index.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: reset, synchronous and active-high.
REQ-005 req  input  N_REQ: per-requester conversion request, level.
REQ-006 bcd_high_i  input  4*N_REQ: tens digit per requester; requester k occupies bits [4k+3:4k].
REQ-007 bcd_low_i  input  4*N_REQ: units digit per requester, packed the same way.
REQ-008 ack  output  N_REQ: one-cycle pulse to the requester whose conversion completed.
REQ-009 bin_o  output  7: converted binary value, 0..99.
REQ-010 bin_vld  output  1: one-cycle pulse marking bin_o and bin_id valid.
REQ-011 bin_id  output  ID_W: index of the requester that owns bin_o.
REQ-012 busy  output  1: high whenever the state is not IDLE.
REQ-013 err_o  output  1: invalid-digit flag, qualified by bin_vld (see Configuration).

Function
REQ-014 The FSM SHALL have exactly three states, IDLE, CONV and DONE, and SHALL hold one registered operand pair plus a round-robin pointer.
REQ-015 In IDLE with req == 0, the block SHALL remain in IDLE.
REQ-016 In IDLE with any req bit set, the block SHALL:
- grant the first set bit found by searching upward, with wrap-around, from (last_grant+1) mod N_REQ;
- latch that requester's two digits and its index;
- go to CONV.
REQ-017 In CONV, the block SHALL present the latched digits to the converter and register its 7-bit result, then go to DONE.
REQ-018 In DONE, the block SHALL pulse bin_vld and ack[bin_id] for exactly one cycle, update last_grant to bin_id, and return to IDLE.
REQ-019 Latency from a grant in IDLE to bin_vld SHALL be exactly 2 cycles; throughput SHALL be one conversion per 3 cycles.
REQ-020 Operands SHALL be sampled only at grant; later changes to the digits, or deassertion of req, SHALL NOT alter or abort an in-flight conversion, and its ack SHALL still pulse.
REQ-021 A requester whose req is still high in the cycle after its ack SHALL be treated as a new request.
REQ-022 When several requests are simultaneous, no requester SHALL wait more than N_REQ-1 grants.
REQ-023 A digit greater than 9 SHALL be converted as 0 before the arithmetic (high*10 + low), so bin_o never exceeds 99.
REQ-024 bin_o and bin_id SHALL hold their last value between bin_vld pulses.
REQ-025 ack SHALL be one-hot or zero in every cycle.

Reset
REQ-026 On rst, the block SHALL set the state to IDLE, last_grant to N_REQ-1 (so requester 0 has first priority), bin_o to 0, bin_id to 0, and ack, bin_vld, busy and err_o to 0.
REQ-027 Reset asserted in CONV or DONE SHALL abort the conversion with no ack or bin_vld pulse, and reset SHALL take priority over every other transition.

Configuration
REQ-028 Macro BCD_ARB_DIGIT_CHECK_EN controls invalid-digit reporting:
- defined: err_o SHALL pulse with bin_vld when either latched digit was greater than 9;
- undefined: err_o SHALL be tied to 0 and no check logic SHALL be synthesized.

Structure
REQ-029 Shared package clock_pkg SHALL hold:
- the state enum (IDLE, CONV, DONE);
- the BCD digit width (4) and binary field width (7);
- the requester indices SEC, MIN and HR.
REQ-030 The converter SHALL be a single instance of the existing bcd2bin module; no other sub-module SHALL be used.

Verification
REQ-031 Reset, then req=3'b001 with seconds digits high=4, low=5 -> bin_vld 2 cycles after grant, bin_o=45, bin_id=0, ack=3'b001.
REQ-032 req=3'b111 held, with hr=2/3, min=5/9 and sec=0/7 -> results in order id0=7, id1=59, id2=23, then id0 again, with 3 cycles between bin_vld pulses.
REQ-033 Minutes digits high=12, low=3 -> bin_o=3, and err_o=1 only when BCD_ARB_DIGIT_CHECK_EN is defined.
REQ-034 Change the digits to 9/9 and drop req the cycle after the grant of 1/2 -> bin_o=12 and ack still pulses.
REQ-035 Assert rst in CONV -> the next cycle shows IDLE, busy=0 and no bin_vld, and requester 0 is granted first after reset.
REQ-036 Over a random 10,000-cycle run with a scoreboard, check that ack is one-hot or zero and that no requester waits more than 2 grants.
